// File: rtl/sched_pkg.sv
// Shared scheduler types and constants for the request-side dispatch logic.
package sched_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACK
    } disp_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/index_decoder.sv
// Index to one-hot decoder; the output is all-zero when en is low.
module index_decoder
    import sched_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output req_vec_t         onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/grant_dispatcher.sv
// Holds pending requests, offers the arbiter's winner downstream and acks the source.
// Optional OFFER timeout is built when GRANT_DISPATCH_TIMEOUT_EN is defined.
module grant_dispatcher
    import sched_pkg::*;
`ifdef GRANT_DISPATCH_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  req_vec_t         req_set,
    output req_vec_t         req_to_arb,
    input  logic [IDX_W-1:0] arb_grant_index,
    input  logic             arb_valid,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    input  logic             out_ready,
    output req_vec_t         ack,
    output req_vec_t         pending,
    output logic             busy,
    output logic             timeout_flag,
    input  logic             timeout_clr
);

    disp_state_t      state_q, state_d;
    req_vec_t         pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    req_vec_t         inflight_mask;
    req_vec_t         ack_vec;
    logic             timeout_hit;

    index_decoder u_inflight_dec (
        .idx    (idx_q),
        .en     (state_q != IDLE),
        .onehot (inflight_mask)
    );

    index_decoder u_ack_dec (
        .idx    (idx_q),
        .en     (state_q == ACK),
        .onehot (ack_vec)
    );

`ifdef GRANT_DISPATCH_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            flag_q, flag_d;

    always_comb begin
        cnt_inc     = cnt_q + TO_W'(1);
        timeout_hit = (state_q == OFFER) && !out_ready && (cnt_inc == TO_W'(TIMEOUT));
        cnt_d       = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == OFFER && !out_ready) begin
            cnt_d = cnt_inc;
        end
        // A timeout in the same cycle as a clear leaves the flag set.
        flag_d = (flag_q & ~timeout_clr) | timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`else
    logic unused_timeout_clr;
    assign unused_timeout_clr = timeout_clr;
    assign timeout_hit        = 1'b0;
    assign timeout_flag       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    idx_d   = arb_grant_index;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    state_d = ACK;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set wins over the ack-driven clear on the same bit.
    assign pending_d = (pending_q & ~ack_vec) | req_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
        end
    end

    assign req_to_arb = pending_q & ~inflight_mask;
    assign out_valid  = (state_q == OFFER);
    assign out_index  = out_valid ? idx_q : '0;
    assign ack        = ack_vec;
    assign pending    = pending_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_grant_dispatcher.sv
// Randomized and directed self-checking bench for grant_dispatcher.
module tb_grant_dispatcher;

`ifdef GRANT_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_set = '0;
    logic [15:0] req_to_arb;
    logic [3:0]  arb_grant_index = '0;
    logic        arb_valid = 1'b0;
    logic        out_valid;
    logic [3:0]  out_index;
    logic        out_ready = 1'b0;
    logic [15:0] ack;
    logic [15:0] pending;
    logic        busy;
    logic        timeout_flag;
    logic        timeout_clr = 1'b0;

    always #5 clk = ~clk;

`ifdef GRANT_DISPATCH_TIMEOUT_EN
    grant_dispatcher #(.TIMEOUT(TB_TIMEOUT), .TO_W(8)) dut (
`else
    grant_dispatcher dut (
`endif
        .clk             (clk),
        .rst             (rst),
        .req_set         (req_set),
        .req_to_arb      (req_to_arb),
        .arb_grant_index (arb_grant_index),
        .arb_valid       (arb_valid),
        .out_valid       (out_valid),
        .out_index       (out_index),
        .out_ready       (out_ready),
        .ack             (ack),
        .pending         (pending),
        .busy            (busy),
        .timeout_flag    (timeout_flag),
        .timeout_clr     (timeout_clr)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: a set of waiting sources plus the source currently being
    // offered (-1 when none) and whether that offer has just been accepted.
    bit [15:0] m_pend;
    int        m_offer;
    bit        m_accepted;
    int        m_stall;
    bit        m_flag;
    int        ack_cnt[16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [15:0] bit_of(input int i);
        bit [15:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input bit [15:0] v, input bit rnd);
        int start;
        start = rnd ? int'($urandom_range(0, 15)) : 0;
        for (int k = 0; k < 16; k++) begin
            if (v[(start + k) % 16]) return (start + k) % 16;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pend     = '0;
        m_offer    = -1;
        m_accepted = 1'b0;
        m_stall    = 0;
        m_flag     = 1'b0;
    endtask

    task automatic check_outputs();
        bit offering;
        offering = (m_offer >= 0) && !m_accepted;
        check("req_to_arb", req_to_arb, m_pend & ~bit_of(m_offer));
        check("out_valid", out_valid, offering);
        check("out_index", out_index, offering ? m_offer : 0);
        check("ack", ack, m_accepted ? bit_of(m_offer) : 16'h0);
        check("pending", pending, m_pend);
        check("busy", busy, m_offer >= 0);
        check("timeout_flag", timeout_flag, m_flag);
        for (int i = 0; i < 16; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
    endtask

    // One clock: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic cycle(input bit [15:0] rs, input bit rdy, input bit clr, input bit rnd);
        bit       av;
        int       gi;
        bit [15:0] retire;
        check_outputs();
        if (m_offer < 0) begin
            av = (m_pend != 0) && (!rnd || $urandom_range(0, 3) != 0);
            gi = av ? pick(m_pend, rnd) : 0;
        end else begin
            av = rnd ? 1'($urandom) : 1'b0;
            gi = rnd ? int'($urandom_range(0, 15)) : 0;
        end
        req_set         = rs;
        out_ready       = rdy;
        timeout_clr     = clr;
        arb_valid       = av;
        arb_grant_index = 4'(gi);
        @(posedge clk);
        retire = m_accepted ? bit_of(m_offer) : 16'h0;
        m_pend = (m_pend & ~retire) | rs;
        if (TO_EN && clr) m_flag = 1'b0;
        if (m_accepted) begin
            m_offer    = -1;
            m_accepted = 1'b0;
        end else if (m_offer >= 0) begin
            if (rdy) begin
                m_accepted = 1'b1;
            end else begin
                m_stall++;
                if (TO_EN && m_stall == TB_TIMEOUT) begin
                    m_offer = -1;
                    m_flag  = 1'b1;
                end
            end
        end else if (av) begin
            m_offer = gi;
            m_stall = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 16; i++) ack_cnt[i] = 0;
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single request on source 4.
        cycle(16'h0010, 0, 0, 0);
        cycle(16'h0000, 0, 0, 0);
        check("single_index", out_index, 4);
        cycle(16'h0000, 1, 0, 0);
        check("single_ack", ack, 16'h0010);
        cycle(16'h0000, 0, 0, 0);
        check("single_drained", pending, 16'h0000);
        cycle(16'h0000, 0, 0, 0);

        // Backpressure with another source waiting.
        cycle(16'h0011, 0, 0, 0);
        cycle(16'h0000, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(16'h0000, 0, 0, 0);
        if (!TO_EN) check("bp_mask", req_to_arb, 16'h0010);
        for (int i = 0; i < 8; i++) cycle(16'h0000, 1, 0, 0);

        // Set and clear colliding on bit 4 during its ack cycle.
        cycle(16'h0010, 0, 0, 0);
        cycle(16'h0000, 0, 0, 0);
        cycle(16'h0000, 1, 0, 0);
        cycle(16'h0010, 0, 0, 0);
        check("collide_keep", pending, 16'h0010);
        cycle(16'h0000, 0, 0, 0);
        check("collide_reoffer", out_index, 4);
        cycle(16'h0000, 1, 0, 0);
        cycle(16'h0000, 0, 0, 0);
        cycle(16'h0000, 0, 0, 0);

        // Asynchronous reset while an offer is held.
        cycle(16'h0008, 0, 0, 0);
        cycle(16'h0000, 0, 0, 0);
        check("rst_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_pending", pending, 16'h0000);
        check("rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(16'h0000, 1, 0, 0);

        // Full load: every source dispatched exactly once in 48 cycles.
        for (int i = 0; i < 16; i++) ack_cnt[i] = 0;
        cycle(16'hFFFF, 1, 0, 0);
        for (int i = 0; i < 48; i++) cycle(16'h0000, 1, 0, 0);
        check("full_drained", pending, 16'h0000);
        for (int i = 0; i < 16; i++) check($sformatf("full_ack_%0d", i), ack_cnt[i], 1);

        if (TO_EN) begin
            // Offer stalls to the limit, is dropped, and the source stays pending.
            cycle(16'h0004, 0, 0, 0);
            cycle(16'h0000, 0, 0, 0);
            for (int i = 0; i < TB_TIMEOUT; i++) cycle(16'h0000, 0, 0, 0);
            check("to_valid", out_valid, 0);
            check("to_flag", timeout_flag, 1);
            check("to_pending", pending, 16'h0004);
            cycle(16'h0000, 0, 1, 0);
            check("to_clr", timeout_flag, 0);
            for (int i = 0; i < 4; i++) cycle(16'h0000, 1, 0, 0);
        end

        // Random traffic with a randomized arbiter.
        for (int i = 0; i < 600; i++) begin
            bit [15:0] rs;
            rs = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0;
            cycle(rs, 1'($urandom_range(0, 2) != 0), $urandom_range(0, 9) == 0, 1);
        end
        for (int i = 0; i < 60; i++) cycle(16'h0000, 1, 0, 0);
        check("final_drained", pending, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
